// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone round-robin arbiter family.
// Holds the arbiter FSM state encoding and the Wishbone B4 burst tag values
// (CTI cycle type identifiers and BTE burst type extensions).

package wb_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } arb_state_t;

   // Cycle type identifier (CTI) encodings
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INC     = 3'b010;
   localparam logic [2:0] CTI_END     = 3'b111;

   // Burst type extension (BTE) encodings
   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin priority encoder.
// Searches req starting one position after last (wrapping modulo N) and
// returns the first requester as a one-hot vector plus its index. The
// "any" flag is low when nothing is requesting, in which case gnt and idx
// are zero.

module wb_rr_pick #(
   parameter int N  = 2,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] cand;

   // Walk the ring from last+1; the first hit wins, later hits are ignored.
   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int i = 1; i <= N; i++) begin
         cand = IW'((int'(last) + i) % N);
         if (!any && req[cand]) begin
            any       = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 arbiter: NUM_MASTERS masters share one slave port.
// Ownership is held for a whole bus cycle (cyc), so bursts and locked
// sequences are never split. The slave request is muxed from a registered
// one-hot grant; responses go combinationally to the owning master only,
// read data is broadcast.
//
// Optional build macro: WB_ARB_TIMEOUT_EN enables a stall watchdog that
// terminates a transfer with err after TIMEOUT_CYCLES unanswered strobes.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no owner; any cyc request is arbitrated at the next edge
//   OWNED | grant/owner registered; held until the owner drops cyc

module wb_rr_arbiter
   import wb_arb_pkg::*;
#(
   parameter int NUM_MASTERS    = 2,
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                          wb_clk_i,
   input  logic                          wb_rst_i,

   input  logic [NUM_MASTERS*AW-1:0]     m_adr_i,
   input  logic [NUM_MASTERS*DW-1:0]     m_dat_i,
   input  logic [NUM_MASTERS*(DW/8)-1:0] m_sel_i,
   input  logic [NUM_MASTERS-1:0]        m_we_i,
   input  logic [NUM_MASTERS-1:0]        m_cyc_i,
   input  logic [NUM_MASTERS-1:0]        m_stb_i,
   input  logic [NUM_MASTERS*3-1:0]      m_cti_i,
   input  logic [NUM_MASTERS*2-1:0]      m_bte_i,
   output logic [DW-1:0]                 m_dat_o,
   output logic [NUM_MASTERS-1:0]        m_ack_o,
   output logic [NUM_MASTERS-1:0]        m_err_o,
   output logic [NUM_MASTERS-1:0]        m_rty_o,

   output logic [AW-1:0]                 s_adr_o,
   output logic [DW-1:0]                 s_dat_o,
   output logic [DW/8-1:0]               s_sel_o,
   output logic                          s_we_o,
   output logic                          s_cyc_o,
   output logic                          s_stb_o,
   output logic [2:0]                    s_cti_o,
   output logic [1:0]                    s_bte_o,
   input  logic [DW-1:0]                 s_dat_i,
   input  logic                          s_ack_i,
   input  logic                          s_err_i,
   input  logic                          s_rty_i,

   output logic [NUM_MASTERS-1:0]        grant_o
);

   localparam int SW = DW / 8;
   localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   arb_state_t             state, state_nxt;
   logic [NUM_MASTERS-1:0] grant, grant_nxt;
   logic [IW-1:0]          owner, owner_nxt;
   logic [IW-1:0]          last, last_nxt;

   logic [NUM_MASTERS-1:0] pick_gnt;
   logic [IW-1:0]          pick_idx;
   logic                   pick_any;

   logic                   grant_valid;
   logic                   cyc_mux;
   logic                   stb_mux;
   logic                   to_hit;
   logic [NUM_MASTERS-1:0] to_err;

   wb_rr_pick #(
      .N  (NUM_MASTERS),
      .IW (IW)
   ) u_pick (
      .req  (m_cyc_i),
      .last (last),
      .gnt  (pick_gnt),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   // State register: FSM state plus the registered grant, owner and last owner.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state <= IDLE;
         grant <= '0;
         owner <= '0;
         last  <= IW'(NUM_MASTERS - 1);
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         owner <= owner_nxt;
         last  <= last_nxt;
      end
   end

   // Next-state logic: arbitrate when idle, release when the owner drops cyc.
   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      owner_nxt = owner;
      last_nxt  = last;
      unique case (state)
         IDLE: begin
            if (pick_any) begin
               state_nxt = OWNED;
               grant_nxt = pick_gnt;
               owner_nxt = pick_idx;
            end
         end
         OWNED: begin
            if (!m_cyc_i[owner]) begin
               state_nxt = IDLE;
               grant_nxt = '0;
               last_nxt  = owner;
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = '0;
         end
      endcase
   end

   assign grant_valid = (state == OWNED);

   // Request mux: forward the owner's slice; everything is zero while idle.
   always_comb begin
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      s_we_o  = 1'b0;
      cyc_mux = 1'b0;
      stb_mux = 1'b0;
      s_cti_o = '0;
      s_bte_o = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (grant_valid && grant[k]) begin
            s_adr_o = m_adr_i[k*AW +: AW];
            s_dat_o = m_dat_i[k*DW +: DW];
            s_sel_o = m_sel_i[k*SW +: SW];
            s_we_o  = m_we_i[k];
            cyc_mux = m_cyc_i[k];
            stb_mux = m_stb_i[k];
            s_cti_o = m_cti_i[k*3 +: 3];
            s_bte_o = m_bte_i[k*2 +: 2];
         end
      end
   end

`ifdef WB_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] to_cnt;
   logic             stall;

   // Stall is judged on the owner's raw strobe so the forced-low strobe on
   // the timeout cycle does not feed back into its own detection.
   assign stall  = stb_mux & ~(s_ack_i | s_err_i | s_rty_i);
   assign to_hit = stall && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Watchdog: count consecutive unanswered strobes, restart on any response.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || !stall || to_hit) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + 1'b1;
      end
   end
`else
   assign to_hit = 1'b0;
`endif

   assign to_err = to_hit ? grant : '0;

   // Outputs: slave strobe/cycle and per-owner response routing.
   always_comb begin
      s_cyc_o = cyc_mux;
      s_stb_o = stb_mux & ~to_hit;
      m_dat_o = s_dat_i;
      m_ack_o = {NUM_MASTERS{s_ack_i}} & grant;
      m_err_o = ({NUM_MASTERS{s_err_i}} & grant) | to_err;
      m_rty_o = {NUM_MASTERS{s_rty_i}} & grant;
      grant_o = grant;
   end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter with two masters.

module tb_wb_rr_arbiter;
   import wb_arb_pkg::*;

   localparam int NM = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NM*AW-1:0]  m_adr;
   logic [NM*DW-1:0]  m_dat;
   logic [NM*SW-1:0]  m_sel;
   logic [NM-1:0]     m_we, m_cyc, m_stb;
   logic [NM*3-1:0]   m_cti;
   logic [NM*2-1:0]   m_bte;
   logic [DW-1:0]     m_dat_o;
   logic [NM-1:0]     m_ack_o, m_err_o, m_rty_o;
   logic [AW-1:0]     s_adr_o;
   logic [DW-1:0]     s_dat_o;
   logic [SW-1:0]     s_sel_o;
   logic              s_we_o, s_cyc_o, s_stb_o;
   logic [2:0]        s_cti_o;
   logic [1:0]        s_bte_o;
   logic [DW-1:0]     s_dat;
   logic              s_ack, s_err, s_rty;
   logic [NM-1:0]     grant_o;

   int n_cmp;
   int n_bad;

   logic [NM-1:0] exp_g [4];
   logic [NM-1:0] err_seen;
   logic          stb_drop;

   wb_rr_arbiter #(
      .NUM_MASTERS    (NM),
      .AW             (AW),
      .DW             (DW),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .m_adr_i  (m_adr),
      .m_dat_i  (m_dat),
      .m_sel_i  (m_sel),
      .m_we_i   (m_we),
      .m_cyc_i  (m_cyc),
      .m_stb_i  (m_stb),
      .m_cti_i  (m_cti),
      .m_bte_i  (m_bte),
      .m_dat_o  (m_dat_o),
      .m_ack_o  (m_ack_o),
      .m_err_o  (m_err_o),
      .m_rty_o  (m_rty_o),
      .s_adr_o  (s_adr_o),
      .s_dat_o  (s_dat_o),
      .s_sel_o  (s_sel_o),
      .s_we_o   (s_we_o),
      .s_cyc_o  (s_cyc_o),
      .s_stb_o  (s_stb_o),
      .s_cti_o  (s_cti_o),
      .s_bte_o  (s_bte_o),
      .s_dat_i  (s_dat),
      .s_ack_i  (s_ack),
      .s_err_i  (s_err),
      .s_rty_i  (s_rty),
      .grant_o  (grant_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int k, input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [2:0] cti);
      m_cyc[k]           = cyc;
      m_stb[k]           = stb;
      m_we[k]            = we;
      m_adr[k*AW +: AW]  = adr;
      m_dat[k*DW +: DW]  = adr ^ 32'h5A5A_0000;
      m_sel[k*SW +: SW]  = 4'hF;
      m_cti[k*3 +: 3]    = cti;
      m_bte[k*2 +: 2]    = BTE_LINEAR;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b1;
      m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0;
      m_cyc = '0; m_stb = '0; m_cti = '0; m_bte = '0;
      s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;

      // ---- reset state, with master 1 already requesting and slave acking
      drive(1, 1'b1, 1'b1, 1'b0, 32'h100, CTI_CLASSIC);
      s_ack = 1'b1;
      step();
      step();
      @(negedge clk);
      chk("rst_grant", grant_o, 2'b00);
      chk("rst_s_cyc", s_cyc_o, 1'b0);
      chk("rst_s_stb", s_stb_o, 1'b0);
      chk("rst_s_adr", s_adr_o, 32'h0);
      chk("rst_m_ack", m_ack_o, 2'b00);
      s_ack = 1'b0;

      // ---- single read by master 1
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("t1_not_yet", s_cyc_o, 1'b0);
      step();
      @(negedge clk);
      chk("t1_grant", grant_o, 2'b10);
      chk("t1_s_cyc", s_cyc_o, 1'b1);
      chk("t1_s_adr", s_adr_o, 32'h100);
      chk("t1_s_we", s_we_o, 1'b0);
      s_ack = 1'b1;
      s_dat = 32'hCAFE_F00D;
      #1;
      chk("t1_m_ack", m_ack_o, 2'b10);
      chk("t1_m_dat", m_dat_o, 32'hCAFE_F00D);
      step();
      s_ack = 1'b0;
      drive(1, 1'b0, 1'b0, 1'b0, 32'h100, CTI_CLASSIC);
      @(negedge clk);
      chk("t1_cyc_drop", s_cyc_o, 1'b0);
      step();
      @(negedge clk);
      chk("t1_grant_clr", grant_o, 2'b00);

      // ---- simultaneous requests after reset alternate 0,1,0,1
      rst = 1'b1;
      drive(0, 1'b1, 1'b1, 1'b0, 32'h10, CTI_CLASSIC);
      drive(1, 1'b1, 1'b1, 1'b1, 32'h20, CTI_CLASSIC);
      step();
      rst = 1'b0;
      step();
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
      for (int p = 0; p < 4; p++) begin
         @(negedge clk);
         chk("t2_grant", grant_o, exp_g[p]);
         chk("t2_s_adr", s_adr_o, (p % 2 == 0) ? 32'h10 : 32'h20);
         s_ack = 1'b1;
         #1;
         chk("t2_m_ack", m_ack_o, exp_g[p]);
         step();
         s_ack = 1'b0;
         drive(p % 2, 1'b0, 1'b0, 1'b0, (p % 2 == 0) ? 32'h10 : 32'h20, CTI_CLASSIC);
         @(negedge clk);
         chk("t2_cyc_drop", s_cyc_o, 1'b0);
         step();
         if (p < 3) drive(p % 2, 1'b1, 1'b1, 1'b0, (p % 2 == 0) ? 32'h10 : 32'h20, CTI_CLASSIC);
         else       drive(0, 1'b0, 1'b0, 1'b0, 32'h10, CTI_CLASSIC);
         @(negedge clk);
         chk("t2_idle_gap", grant_o, 2'b00);
         step();
      end
      @(negedge clk);
      chk("t2_all_idle", grant_o, 2'b00);

      // ---- master 0 4-beat incremental burst while master 1 waits
      drive(0, 1'b1, 1'b1, 1'b0, 32'h200, CTI_INC);
      drive(1, 1'b1, 1'b1, 1'b0, 32'h300, CTI_CLASSIC);
      step();
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         chk("t3_grant", grant_o, 2'b01);
         chk("t3_s_adr", s_adr_o, 32'h200 + 32'(4 * b));
         chk("t3_s_cti", s_cti_o, (b == 3) ? CTI_END : CTI_INC);
         s_ack = 1'b1;
         #1;
         chk("t3_m_ack", m_ack_o, 2'b01);
         step();
         s_ack = 1'b0;
         if (b < 3) drive(0, 1'b1, 1'b1, 1'b0, 32'h200 + 32'(4 * (b + 1)), (b == 2) ? CTI_END : CTI_INC);
         else       drive(0, 1'b0, 1'b0, 1'b0, 32'h200, CTI_CLASSIC);
      end
      @(negedge clk);
      chk("t3_cyc_drop", s_cyc_o, 1'b0);
      chk("t3_m1_noack", m_ack_o, 2'b00);
      step();
      @(negedge clk);
      chk("t3_idle_gap", grant_o, 2'b00);
      step();
      @(negedge clk);
      chk("t3_m1_grant", grant_o, 2'b10);
      chk("t3_m1_adr", s_adr_o, 32'h300);
      s_ack = 1'b1;
      #1;
      chk("t3_m1_ack", m_ack_o, 2'b10);
      step();
      s_ack = 1'b0;
      drive(1, 1'b0, 1'b0, 1'b0, 32'h300, CTI_CLASSIC);
      step();

      // ---- reset during the third beat of a master 1 burst
      drive(0, 1'b1, 1'b1, 1'b1, 32'h400, CTI_CLASSIC);
      step();
      @(negedge clk);
      chk("t4_m0_grant", grant_o, 2'b01);
      chk("t4_m0_we", s_we_o, 1'b1);
      s_ack = 1'b1;
      step();
      s_ack = 1'b0;
      drive(0, 1'b0, 1'b0, 1'b0, 32'h400, CTI_CLASSIC);
      step();
      drive(1, 1'b1, 1'b1, 1'b0, 32'h500, CTI_INC);
      step();
      @(negedge clk);
      chk("t4_m1_grant", grant_o, 2'b10);
      s_ack = 1'b1;
      step();
      drive(1, 1'b1, 1'b1, 1'b0, 32'h504, CTI_INC);
      step();
      drive(1, 1'b1, 1'b1, 1'b0, 32'h508, CTI_INC);
      rst = 1'b1;
      @(negedge clk);
      chk("t4_beat3_adr", s_adr_o, 32'h508);
      chk("t4_beat3_cyc", s_cyc_o, 1'b1);
      step();
      rst   = 1'b0;
      s_ack = 1'b0;
      drive(0, 1'b1, 1'b1, 1'b0, 32'h600, CTI_CLASSIC);
      @(negedge clk);
      chk("t4_rst_cyc", s_cyc_o, 1'b0);
      chk("t4_rst_grant", grant_o, 2'b00);
      step();
      @(negedge clk);
      chk("t4_m0_first", grant_o, 2'b01);
      chk("t4_m0_adr", s_adr_o, 32'h600);
      step();
      drive(0, 1'b0, 1'b0, 1'b0, 32'h600, CTI_CLASSIC);
      drive(1, 1'b0, 1'b0, 1'b0, 32'h500, CTI_CLASSIC);
      step();
      step();

      // ---- err/rty routing, then a slave that never acknowledges
      drive(0, 1'b1, 1'b1, 1'b0, 32'h700, CTI_CLASSIC);
      step();
      @(negedge clk);
      chk("t5_grant", grant_o, 2'b01);
      s_err = 1'b1;
      #1;
      chk("t5_m_err", m_err_o, 2'b01);
      s_err = 1'b0;
      s_rty = 1'b1;
      #1;
      chk("t5_m_rty", m_rty_o, 2'b01);
      chk("t5_no_ack", m_ack_o, 2'b00);
      step();
      s_rty = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
      for (int i = 1; i <= 17; i++) begin
         @(negedge clk);
         chk("t5_to_err", m_err_o, (i == 16) ? 2'b01 : 2'b00);
         chk("t5_to_stb", s_stb_o, (i == 16) ? 1'b0 : 1'b1);
         step();
      end
`else
      err_seen = '0;
      stb_drop = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         err_seen = err_seen | m_err_o;
         stb_drop = stb_drop | ~s_stb_o;
         step();
      end
      chk("t5_no_to_err", err_seen, 2'b00);
      chk("t5_stb_held", stb_drop, 1'b0);
`endif
      drive(0, 1'b0, 1'b0, 1'b0, 32'h700, CTI_CLASSIC);
      step();
      step();
      @(negedge clk);
      chk("t5_end_idle", grant_o, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
